// File: rtl/sram_controller_pkg.sv
// Shared types and helpers for the MEM-stage SRAM controller.
// State encoding, default geometry and byte-to-word address translation.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam int DEF_WORD_W      = 32;
  localparam int DEF_ADDR_W      = 17;
  localparam int DEF_WAIT_CYCLES = 5;
  localparam int DEF_BASE_ADDR   = 1024;

  // Result wraps; callers truncate to the SRAM address width.
  function automatic logic [31:0] to_word_addr(
    input logic [31:0] byte_addr,
    input logic [31:0] base
  );
    return (byte_addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_line_buffer.sv
// One-entry line buffer for sram_controller.
// Present only when SRAM_CTRL_LINE_BUF_EN is defined.
module sram_line_buffer #(
  parameter int WORD_W = 32,
  parameter int TAG_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TAG_W-1:0]    lookup_tag,
  output logic                hit,
  output logic [2*WORD_W-1:0] line,
  input  logic                fill_en,
  input  logic                upd_en,
  input  logic [TAG_W-1:0]    tag,
  input  logic                upd_hi,
  input  logic [2*WORD_W-1:0] fill_line,
  input  logic [WORD_W-1:0]   upd_word
);

  logic                valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [2*WORD_W-1:0] line_q, line_d;

  assign hit  = valid_q && (tag_q == lookup_tag);
  assign line = line_q;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    line_d  = line_q;
    if (fill_en) begin
      valid_d = 1'b1;
      tag_d   = tag;
      line_d  = fill_line;
    end else if (upd_en && valid_q && (tag_q == tag)) begin
      if (upd_hi) line_d[2*WORD_W-1:WORD_W] = upd_word;
      else        line_d[WORD_W-1:0]        = upd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// MEM-stage controller for a 64-bit-read / 32-bit-write SRAM.
// Define SRAM_CTRL_LINE_BUF_EN to add a one-entry line buffer.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [31:0]         address,
  input  logic [WORD_W-1:0]   wr_data,
  output logic [WORD_W-1:0]   rd_data,
  output logic [2*WORD_W-1:0] rd_line,
  output logic                ready,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  inout  wire  [2*WORD_W-1:0] SRAM_DQ,
  output logic                SRAM_WE_N
);

  localparam int LW = 2 * WORD_W;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic [LW-1:0]     rd_line_q, rd_line_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;

  logic [ADDR_W-1:0] req_addr;
  logic              req, last, drive, hit;
  logic [LW-1:0]     hit_line;
  logic [WORD_W-1:0] hit_word, dq_word;

  assign req_addr = ADDR_W'(to_word_addr(address, 32'(BASE_ADDR)));
  assign req      = rd_en | wr_en;
  assign last     = (state_q == ACCESS) && (cnt_q == '0);
  assign drive    = (state_q == ACCESS) && is_wr_q;

  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = !drive;
  assign SRAM_DQ   = drive ? {{WORD_W{1'b0}}, wdata_q} : 'z;

`ifdef SRAM_CTRL_LINE_BUF_EN
  logic          buf_hit;
  logic [LW-1:0] buf_line;

  sram_line_buffer #(
    .WORD_W(WORD_W),
    .TAG_W (ADDR_W - 1)
  ) u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .lookup_tag(req_addr[ADDR_W-1:1]),
    .hit       (buf_hit),
    .line      (buf_line),
    .fill_en   (last && !is_wr_q),
    .upd_en    (last && is_wr_q),
    .tag       (addr_q[ADDR_W-1:1]),
    .upd_hi    (addr_q[0]),
    .fill_line (SRAM_DQ),
    .upd_word  (wdata_q)
  );

  assign hit      = (state_q == IDLE) && rd_en && !wr_en && buf_hit;
  assign hit_line = buf_line;
`else
  assign hit      = 1'b0;
  assign hit_line = rd_line_q;
`endif

  assign hit_word = req_addr[0] ? hit_line[LW-1:WORD_W]
                                : hit_line[WORD_W-1:0];
  assign dq_word  = addr_q[0] ? SRAM_DQ[LW-1:WORD_W]
                              : SRAM_DQ[WORD_W-1:0];

  assign rd_data = hit ? hit_word : rd_data_q;
  assign rd_line = rd_line_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    rd_line_d = rd_line_q;
    rd_data_d = rd_data_q;
    ready     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = hit || !req;
        if (hit) begin
          rd_line_d = hit_line;
          rd_data_d = hit_word;
        end else if (req) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          addr_d  = req_addr;
          wdata_d = wr_data;
          is_wr_d = wr_en;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 4'd1;
        // Line is sampled off the bus on the final access cycle.
        if (last && !is_wr_q) begin
          rd_line_d = SRAM_DQ;
          rd_data_d = dq_word;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_wr_q   <= 1'b0;
      rd_line_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      rd_line_q <= rd_line_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Parametrised controller between the MEM stage and the external 64-bit-read / 32-bit-write SRAM.
- Translates byte addresses to SRAM word addresses and sequences read/write accesses over a configurable number of wait states.
- Returns the selected word plus the full line.
- Holds `ready` low to freeze the pipeline while an access is in flight.

Parameters:
- WORD_W, 32: data word width; SRAM_DQ is 2*WORD_W wide.
- ADDR_W, 17: SRAM word-address width.
- WAIT_CYCLES, 5: SRAM access cycles per request; legal range 1..15.
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- address  in  32  byte address.
- wr_data  in  WORD_W  write data.
- rd_data  out  WORD_W  read word selected by word-address bit 0.
- rd_line  out  2*WORD_W  full fetched line, {high word, low word}.
- ready  out  1  1 = no stall; 0 = freeze pipeline.
- SRAM_ADDR  out  ADDR_W  SRAM word address.
- SRAM_DQ  inout  2*WORD_W  SRAM data bus.
- SRAM_WE_N  out  1  SRAM write enable, active low.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Address translation: word_addr = ((address - BASE_ADDR) >> 2), truncated to ADDR_W bits. No range check; overflow wraps modulo 2^ADDR_W.
- Reset values: state IDLE, SRAM_WE_N=1, SRAM_ADDR=0, rd_data=0, rd_line=0, SRAM_DQ=z, wait counter 0.
- Reset mid-access: the access is aborted. SRAM_WE_N is 1 and SRAM_DQ is z from the first cycle after reset.
- FSM state IDLE:
  - ready = !(rd_en | wr_en), combinational.
  - A request is latched (address, wr_data, type) at the clock edge; next state is ACCESS and the counter is loaded with WAIT_CYCLES-1.
  - If wr_en and rd_en are both set, the write wins.
- FSM state ACCESS:
  - Lasts exactly WAIT_CYCLES cycles; the counter decrements each cycle.
  - SRAM_ADDR = latched word_addr.
  - Write: SRAM_WE_N=0, SRAM_DQ = {WORD_W'b0, latched wr_data}; the SRAM stores the low lane at SRAM_ADDR.
  - Read: SRAM_WE_N=1, SRAM_DQ=z.
  - On the last ACCESS cycle of a read, SRAM_DQ is registered into rd_line.
  - At counter 0, next state is DONE.
  - ready=0 throughout ACCESS.
  - Changes on request inputs during ACCESS are ignored.
- FSM state DONE:
  - One cycle; ready=1; SRAM_WE_N=1; SRAM_DQ=z.
  - rd_data = latched word_addr[0] ? rd_line[2*WORD_W-1:WORD_W] : rd_line[WORD_W-1:0].
  - The request is consumed at this edge; next state is IDLE.
  - IDLE samples inputs fresh on the next cycle, so back-to-back requests each pay the full latency.
- Latency: ready rises WAIT_CYCLES+1 cycles after the IDLE accept cycle.
- rd_data and rd_line hold their values until the next read completes; writes do not alter them.
- SRAM_DQ is never driven outside write ACCESS cycles, so there is no bus contention on write→read turnaround.

Optional Feature:
- Macro: SRAM_CTRL_LINE_BUF_EN.
- When defined: a one-entry line buffer holds {valid, line tag = word_addr[ADDR_W-1:1], rd_line}.
  - A read in IDLE that hits a valid buffer gives ready=1 combinationally.
  - rd_data is driven from the buffer in that same cycle; there is no ACCESS.
  - A completed read fills the buffer and sets valid.
  - A write to the buffered tag updates the matching half in the buffer when its ACCESS completes.
  - Reset clears valid.
- When undefined: every read takes the full FSM path, and no buffer registers exist.

Decomposition:
- Shared package holds:
  - state encoding typedef {IDLE, ACCESS, DONE};
  - default WAIT_CYCLES, BASE_ADDR, WORD_W constants;
  - address-translation function.
- One natural sub-module: sram_line_buffer (tag/valid/data, hit compare, fill/update), instantiated only under the macro.

Test Plan:
- Reset: rst=1 for 2 cycles, then rst=0 with no request -> ready=1, SRAM_WE_N=1, SRAM_DQ=z, rd_data=0.
- Write/read round trip:
  - Write 0xDEADBEEF to address 1028 -> SRAM_ADDR=1, SRAM_WE_N=0 for exactly 5 cycles, ready high 6 cycles after accept.
  - Read 1028 -> rd_data=0xDEADBEEF (high lane).
  - Read 1024 -> low-lane word.
- Simultaneous rd_en=1 and wr_en=1 at address 1032 -> write performed (SRAM_WE_N=0), rd_data unchanged.
- Reset at the 3rd ACCESS cycle of a write -> SRAM_WE_N=1 and SRAM_DQ=z on the next cycle, state IDLE, ready follows inputs.
- WAIT_CYCLES=1 instance: read -> ready at cycle 2 after accept; address wrap check BASE_ADDR + 4*2^17 -> SRAM_ADDR=0.
- SRAM_CTRL_LINE_BUF_EN:
  - Read 1024 (miss, 6 cycles), then read 1028 -> ready=1 in the IDLE cycle with no SRAM access.
  - Write 1028 then read 1028 -> new data from the buffer.
